// File: rtl/divisor_frecuencia_if.sv
// Output bundle of the clock divider: the three derived square waves.
interface divisor_frecuencia_if;
  logic clockseg;
  logic clockmin;
  logic clockhor;

  modport master (output clockseg, output clockmin, output clockhor);
  modport slave  (input  clockseg, input  clockmin, input  clockhor);
endinterface

// File: rtl/divisor_frecuencia.sv
// Clock divider: derives 50%-duty second/minute/hour square waves from the
// system clock. Every output is a flop; minute and hour edges are aligned to
// the falling edge of the next-faster output.
module divisor_frecuencia #(
  parameter int SEG_DIV      = 100_000_000,
  parameter int SEC_PER_MIN  = 60,
  parameter int MIN_PER_HOUR = 60
) (
  input  logic                   clock,
  input  logic                   reset,
  divisor_frecuencia_if.master   out_if
);

  localparam int HALF  = SEG_DIV / 2;
  // A modulus of 1 would give a zero-width counter; keep at least one bit.
  localparam int HC_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int SEC_W = $clog2(SEC_PER_MIN);
  localparam int MIN_W = $clog2(MIN_PER_HOUR);

  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HALF - 1);
  localparam logic [SEC_W-1:0] SEC_MID  = SEC_W'(SEC_PER_MIN / 2 - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_MIN - 1);
  localparam logic [MIN_W-1:0] MIN_MID  = MIN_W'(MIN_PER_HOUR / 2 - 1);
  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_PER_HOUR - 1);

  logic [HC_W-1:0]  hc_q,  hc_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic             seg_q, seg_d;
  logic             mnt_q, mnt_d;
  logic             hor_q, hor_d;
  logic             hc_wrap;
  logic             tick_s;
  logic             tick_m;

  // Next-state: prescaler toggles clockseg; clockseg falls mark seconds,
  // clockmin falls mark minutes.
  always_comb begin
    hc_wrap = (hc_q == HC_LAST);
    tick_s  = hc_wrap && seg_q;
    tick_m  = tick_s && (sec_q == SEC_LAST);

    hc_d  = hc_wrap ? '0 : hc_q + HC_W'(1);
    seg_d = hc_wrap ? ~seg_q : seg_q;

    sec_d = sec_q;
    mnt_d = mnt_q;
    if (tick_s) begin
      sec_d = (sec_q == SEC_LAST) ? '0 : sec_q + SEC_W'(1);
      if (sec_q == SEC_MID || sec_q == SEC_LAST) mnt_d = ~mnt_q;
    end

    min_d = min_q;
    hor_d = hor_q;
    if (tick_m) begin
      min_d = (min_q == MIN_LAST) ? '0 : min_q + MIN_W'(1);
      if (min_q == MIN_MID || min_q == MIN_LAST) hor_d = ~hor_q;
    end
  end

  // State and output registers; reset returns everything to the zero state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hc_q  <= '0;
      sec_q <= '0;
      min_q <= '0;
      seg_q <= 1'b0;
      mnt_q <= 1'b0;
      hor_q <= 1'b0;
    end else begin
      hc_q  <= hc_d;
      sec_q <= sec_d;
      min_q <= min_d;
      seg_q <= seg_d;
      mnt_q <= mnt_d;
      hor_q <= hor_d;
    end
  end

  assign out_if.clockseg = seg_q;
  assign out_if.clockmin = mnt_q;
  assign out_if.clockhor = hor_q;

endmodule

// File: tb/tb_divisor_frecuencia.sv
// Directed bench for divisor_frecuencia: small-ratio instance for reset,
// edge timing and alignment; 10/60/60 instance for duty cycle and periods.
module tb_divisor_frecuencia;

  logic clock = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clock = ~clock;

  divisor_frecuencia_if ifa ();
  divisor_frecuencia_if ifb ();

  divisor_frecuencia #(.SEG_DIV(4), .SEC_PER_MIN(4), .MIN_PER_HOUR(4)) dut_a (
    .clock (clock),
    .reset (reset_a),
    .out_if(ifa.master)
  );

  divisor_frecuencia #(.SEG_DIV(10), .SEC_PER_MIN(60), .MIN_PER_HOUR(60)) dut_b (
    .clock (clock),
    .reset (reset_b),
    .out_if(ifb.master)
  );

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic       pseg, pmin, phor;
    int         r1[3], f1[3], r2[3];
    logic [2:0] prev, cur;

    // ---- reset held for 3 cycles ----
    repeat (3) step();
    chk("rst_seg", ifa.clockseg, 0);
    chk("rst_min", ifa.clockmin, 0);
    chk("rst_hor", ifa.clockhor, 0);

    // ---- 4/4/4: two full hour periods, edge-by-edge ----
    @(negedge clock); reset_a = 1'b0;
    pseg = 1'b0; pmin = 1'b0; phor = 1'b0;
    for (int n = 1; n <= 128; n++) begin
      step();
      chk($sformatf("seg@%0d", n), ifa.clockseg, (n / 2) % 2);
      chk($sformatf("min@%0d", n), ifa.clockmin, (n / 8) % 2);
      chk($sformatf("hor@%0d", n), ifa.clockhor, (n / 32) % 2);
      if (ifa.clockmin != pmin)
        chk($sformatf("min_align@%0d", n), {pseg, ifa.clockseg}, 2);
      if (ifa.clockhor != phor)
        chk($sformatf("hor_align@%0d", n), {pmin, ifa.clockmin}, 2);
      pseg = ifa.clockseg; pmin = ifa.clockmin; phor = ifa.clockhor;
    end

    // ---- mid-operation asynchronous reset at edge 37 ----
    @(negedge clock); reset_a = 1'b1;
    step();
    @(negedge clock); reset_a = 1'b0;
    repeat (37) step();
    chk("pre_rst_hor", ifa.clockhor, 1);
    #3 reset_a = 1'b1;
    #1;
    chk("async_seg", ifa.clockseg, 0);
    chk("async_min", ifa.clockmin, 0);
    chk("async_hor", ifa.clockhor, 0);
    step(); step();
    chk("held_hor", ifa.clockhor, 0);
    @(negedge clock); reset_a = 1'b0;
    step();
    chk("restart_seg@1", ifa.clockseg, 0);
    step();
    chk("restart_seg@2", ifa.clockseg, 1);

    // ---- 10/60/60: duty cycle and periods of all outputs ----
    for (int i = 0; i < 3; i++) begin r1[i] = -1; f1[i] = -1; r2[i] = -1; end
    @(negedge clock); reset_b = 1'b0;
    prev = 3'b000;
    for (int n = 1; n <= 54010 && r2[2] < 0; n++) begin
      step();
      cur = {ifb.clockhor, ifb.clockmin, ifb.clockseg};
      for (int i = 0; i < 3; i++) begin
        if (cur[i] && !prev[i]) begin
          if (r1[i] < 0) r1[i] = n;
          else if (r2[i] < 0) r2[i] = n;
        end
        if (!cur[i] && prev[i] && f1[i] < 0) f1[i] = n;
      end
      prev = cur;
    end
    chk("seg_rise",   r1[0], 5);
    chk("seg_high",   f1[0] - r1[0], 5);
    chk("seg_low",    r2[0] - f1[0], 5);
    chk("seg_period", r2[0] - r1[0], 10);
    chk("min_rise",   r1[1], 300);
    chk("min_high",   f1[1] - r1[1], 300);
    chk("min_low",    r2[1] - f1[1], 300);
    chk("min_period", r2[1] - r1[1], 600);
    chk("hor_rise",   r1[2], 18000);
    chk("hor_high",   f1[2] - r1[2], 18000);
    chk("hor_low",    r2[2] - f1[2], 18000);
    chk("hor_period", r2[2] - r1[2], 36000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/divisor_frecuencia.md
Name: divisor_frecuencia

Overview:
Clock divider for the digital-clock design. From the single system clock it derives three 50%-duty square-wave "clocks": clockseg (1 Hz), clockmin (1/60 Hz) and clockhor (1/3600 Hz). All logic is synchronous to `clock` with an asynchronous reset. The outputs are registered signals that downstream seconds/minutes/hours counters use as edge or level sources.

Parameters:
- SEG_DIV, 100_000_000, number of `clock` cycles per clockseg period; must be even and >= 2. HALF = SEG_DIV/2.
- SEC_PER_MIN, 60, clockseg periods per clockmin period; must be even and >= 2.
- MIN_PER_HOUR, 60, clockmin periods per clockhor period; must be even and >= 2.

Ports:
- clock, input, 1, system clock; the bench uses a 10 ns period (100 MHz).
- reset, input, 1, asynchronous, active-high; clears all state.
- clockseg, output, 1, square wave, period SEG_DIV cycles.
- clockmin, output, 1, square wave, period SEG_DIV*SEC_PER_MIN cycles.
- clockhor, output, 1, square wave, period SEG_DIV*SEC_PER_MIN*MIN_PER_HOUR cycles.

Behaviour:
- Reset asserted, asynchronously: the prescaler hc, sec_cnt and min_cnt all go to 0, and clockseg, clockmin and clockhor all go to 0. Outputs hold 0 while reset is high.
- Reset may assert at any cycle, mid-period included. After release, counting restarts from the zero state; there is no partial period carried over.
- Prescaler hc counts 0..HALF-1.
  - When hc==HALF-1: hc wraps to 0 and clockseg toggles.
  - Otherwise hc increments.
- tick_s = (hc==HALF-1) && clockseg==1, i.e. the cycle in which clockseg falls. This marks one completed second.
- sec_cnt counts 0..SEC_PER_MIN-1 and advances only on tick_s, wrapping from SEC_PER_MIN-1 to 0.
- clockmin toggles on tick_s when sec_cnt == SEC_PER_MIN/2-1 (rises) or when sec_cnt == SEC_PER_MIN-1 (falls).
- tick_m = tick_s && sec_cnt==SEC_PER_MIN-1, i.e. the cycle in which clockmin falls.
- min_cnt counts 0..MIN_PER_HOUR-1 and advances only on tick_m, wrapping from MIN_PER_HOUR-1 to 0.
- clockhor toggles on tick_m when min_cnt == MIN_PER_HOUR/2-1 (rises) or when min_cnt == MIN_PER_HOUR-1 (falls).
- Edge alignment: every clockmin edge coincides with a clockseg falling edge on the same `clock` edge. Every clockhor edge coincides with a clockmin falling edge. No output glitches, because all outputs come directly from flops.
- Timing after reset release, counted in `clock` rising edges N:
  - clockseg first rises at N=HALF and falls at N=SEG_DIV.
  - clockmin first rises at N=SEG_DIV*SEC_PER_MIN/2.
  - clockhor first rises at N=SEG_DIV*SEC_PER_MIN*MIN_PER_HOUR/2.
- Wrap-around: after one full hour of periods, all counters and outputs are back at 0 simultaneously. Operation is free-running and periodic.
- Counter widths: each counter is sized with $clog2 of its modulus; no overflow beyond the modulus is permitted.
- There is no enable input and no other inputs.

Test Plan:
- Reset check (SEG_DIV=4, SEC_PER_MIN=4, MIN_PER_HOUR=4): assert reset for 3 cycles -> all outputs 0; release -> clockseg rises at edge 2, falls at edge 4, period 4.
- clockmin timing (same parameters): clockmin rises at edge 8, falls at edge 16, period 16. Each clockmin transition occurs on the same edge as a clockseg falling edge.
- clockhor timing (same parameters): clockhor rises at edge 32, falls at edge 64. At edge 64 all three outputs are 0, and the pattern repeats identically through edge 128.
- Mid-operation reset: assert reset asynchronously (between clock edges) at edge 37 while clockhor=1 -> all outputs drop to 0 immediately. After release, clockseg first rises 2 edges later.
- Duty cycle with default-style ratios (SEG_DIV=10, SEC_PER_MIN=60, MIN_PER_HOUR=60): the high time equals the low time for every output. Measured periods are 10, 600 and 36000 cycles.
- Defaults sanity: with the default SEG_DIV=100_000_000 and a 10 ns clock, clockseg has a 1 s period (first rise at 500 ms after reset), checked via a long run or a forced-counter shortcut.
